// File: rtl/prewish_pkg.sv
// Shared status/command bit positions and debounced-state encoding for prewish_debounce.
// Constants only: no latency and no flow control.
package prewish_pkg;

   localparam int STAT_STATE   = 0;
   localparam int STAT_PRESS   = 1;
   localparam int STAT_RELEASE = 2;

   localparam int CMD_READ  = 0;
   localparam int CMD_CLEAR = 1;

   typedef enum logic {
      BTN_RELEASED = 1'b0,
      BTN_PRESSED  = 1'b1
   } btn_state_e;

endpackage

// File: rtl/prewish_sync2.sv
// Two-flop synchronizer with a selectable reset value.
// Latency: 2 CLK cycles. No backpressure: it samples every cycle.
module prewish_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ff_q <= {2{RST_VAL}};
      end else begin
         ff_q <= {ff_q[0], d_i};
      end
   end

   assign q_o = ff_q[1];

endmodule

// File: rtl/prewish_debounce.sv
// Button debouncer with a strobe/byte status interface; `PREWISH_DEBOUNCE_AUTO_REPORT_EN adds unsolicited reports.
// Read response 1 cycle after STB_I; state changes 1 cycle after a tick. No backpressure: STB_O is never held off.
module prewish_debounce
   import prewish_pkg::*;
#(
   parameter int NUM_SAMPLES    = 2,
   parameter int ALIVE_DIV_BITS = 3
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   output logic       STB_O,
   output logic [7:0] DAT_O,
   input  logic       STB_I,
   input  logic [7:0] DAT_I,
   input  logic       iN_button,
   input  logic       i_dbclock,
   output logic       o_alive
);

   localparam logic [ALIVE_DIV_BITS-1:0] ALIVE_ONE = 1;

   logic                      btn_sync;
   logic                      dbc_sync;
   logic                      dbc_prev_q;
   logic                      tick;
   logic                      eval_q;
   logic [NUM_SAMPLES-1:0]    hist_q, hist_d;
   btn_state_e                state_q, state_d;
   logic                      press_q, press_d;
   logic                      rel_q, rel_d;
   logic                      stb_q, stb_d;
   logic [7:0]                dat_q, dat_d;
   logic [ALIVE_DIV_BITS-1:0] alive_cnt_q, alive_cnt_d;
   logic                      alive_q, alive_d;
   logic                      set_press, set_rel;
   logic                      rd_cmd, clr_cmd;
   logic [7:0]                status;
   logic                      unused_dat;

   assign unused_dat = ^DAT_I[7:2];

   // The button pin idles high (released) so its synchronizer resets to 1.
   prewish_sync2 #(.RST_VAL(1'b1)) u_sync_btn (
      .clk_i (CLK_I),
      .rst_ni(RST_I),
      .d_i   (iN_button),
      .q_o   (btn_sync)
   );

   prewish_sync2 #(.RST_VAL(1'b0)) u_sync_dbc (
      .clk_i (CLK_I),
      .rst_ni(RST_I),
      .d_i   (i_dbclock),
      .q_o   (dbc_sync)
   );

   assign tick = dbc_sync & ~dbc_prev_q;

`ifdef PREWISH_DEBOUNCE_AUTO_REPORT_EN
   logic auto_pend_q, auto_pend_d;

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         auto_pend_q <= 1'b0;
      end else begin
         auto_pend_q <= auto_pend_d;
      end
   end
`endif

   always_comb begin
      hist_d      = hist_q;
      state_d     = state_q;
      alive_cnt_d = alive_cnt_q;
      alive_d     = alive_q;
      dat_d       = dat_q;
      set_press   = 1'b0;
      set_rel     = 1'b0;
      rd_cmd      = STB_I & DAT_I[CMD_READ];
      clr_cmd     = STB_I & (DAT_I[CMD_READ] | DAT_I[CMD_CLEAR]);

      status               = '0;
      status[STAT_STATE]   = (state_q == BTN_PRESSED);
      status[STAT_PRESS]   = press_q;
      status[STAT_RELEASE] = rel_q;

      if (tick) begin
         hist_d      = {hist_q[NUM_SAMPLES-2:0], ~btn_sync};
         alive_cnt_d = alive_cnt_q + ALIVE_ONE;
         if (&alive_cnt_q) begin
            alive_d = ~alive_q;
         end
      end

      if (eval_q) begin
         if ((&hist_q) && (state_q == BTN_RELEASED)) begin
            state_d   = BTN_PRESSED;
            set_press = 1'b1;
         end else if ((~|hist_q) && (state_q == BTN_PRESSED)) begin
            state_d = BTN_RELEASED;
            set_rel = 1'b1;
         end
      end

      // A flag raised on the same edge as a clear survives it.
      press_d = (press_q & ~clr_cmd) | set_press;
      rel_d   = (rel_q & ~clr_cmd) | set_rel;

      stb_d = rd_cmd;
`ifdef PREWISH_DEBOUNCE_AUTO_REPORT_EN
      auto_pend_d = set_press | set_rel;
      if (auto_pend_q) begin
         stb_d = 1'b1;
      end
`endif
      if (stb_d) begin
         dat_d = status;
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         dbc_prev_q  <= 1'b0;
         eval_q      <= 1'b0;
         hist_q      <= '0;
         state_q     <= BTN_RELEASED;
         press_q     <= 1'b0;
         rel_q       <= 1'b0;
         stb_q       <= 1'b0;
         dat_q       <= '0;
         alive_cnt_q <= '0;
         alive_q     <= 1'b0;
      end else begin
         dbc_prev_q  <= dbc_sync;
         eval_q      <= tick;
         hist_q      <= hist_d;
         state_q     <= state_d;
         press_q     <= press_d;
         rel_q       <= rel_d;
         stb_q       <= stb_d;
         dat_q       <= dat_d;
         alive_cnt_q <= alive_cnt_d;
         alive_q     <= alive_d;
      end
   end

   assign STB_O   = stb_q;
   assign DAT_O   = dat_q;
   assign o_alive = alive_q;

endmodule

// File: tb/tb_prewish_debounce.sv
// Scoreboard bench for prewish_debounce: stimulus pushes expected status bytes, a monitor pops them on STB_O.
// Debounce tick period is 128 clocks; button changes are aligned 8 clocks after a bench tick edge.
module tb_prewish_debounce;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       stb_i;
   logic [7:0] dat_i;
   logic       btn_n;
   logic       dbclk;
   logic       stb_o;
   logic [7:0] dat_o;
   logic       alive;

   int         checks = 0;
   int         errors = 0;
   int         alive_checks = 0;
   int         tick_cnt = 0;
   logic [7:0] exp_q[$];
   logic [15:0] lfsr = 16'hACE1;

   always #5 clk = ~clk;

   prewish_debounce #(.NUM_SAMPLES(2), .ALIVE_DIV_BITS(3)) dut (
      .CLK_I    (clk),
      .RST_I    (rst_n),
      .STB_O    (stb_o),
      .DAT_O    (dat_o),
      .STB_I    (stb_i),
      .DAT_I    (dat_i),
      .iN_button(btn_n),
      .i_dbclock(dbclk),
      .o_alive  (alive)
   );

   initial begin
      dbclk = 1'b0;
      forever begin
         repeat (64) @(negedge clk);
         dbclk = ~dbclk;
         if (dbclk) tick_cnt++;
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (rst_n === 1'b1 && stb_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_stb: got DAT_O=%02h, expected no response at %0t", dat_o, $time);
         end else begin
            check("response", dat_o, exp_q.pop_front());
         end
      end
   end

   // Heartbeat monitor: consecutive toggles must be exactly 8 bench ticks apart
   logic alive_prev;
   bit   have_last;
   int   last_toggle;
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         alive_prev = 1'b0;
         have_last  = 1'b0;
      end else if (alive !== alive_prev) begin
         alive_prev = alive;
         if (have_last) begin
            check("alive_period", tick_cnt - last_toggle, 8);
            alive_checks++;
         end
         have_last   = 1'b1;
         last_toggle = tick_cnt;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) @(posedge dbclk);
      idle(8);
   endtask

   task automatic cmd(input logic [7:0] d);
      stb_i = 1'b1;
      dat_i = d;
      @(negedge clk);
      stb_i = 1'b0;
      dat_i = 8'h00;
   endtask

   task automatic read_cmd(input logic [7:0] e);
      exp_q.push_back(e);
      cmd(8'h01);
   endtask

   task automatic auto_exp(input logic [7:0] e);
`ifdef PREWISH_DEBOUNCE_AUTO_REPORT_EN
      exp_q.push_back(e);
`else
      if (e === 8'hxx) $display("auto report byte undefined");
`endif
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      stb_i = 1'b0;
      dat_i = 8'h00;
      btn_n = 1'b1;
      idle(1);
      check("rst_stb", stb_o, 0);
      check("rst_dat", dat_o, 0);
      check("rst_alive", alive, 0);
      idle(14);
      rst_n = 1'b1;
      idle(2);
      read_cmd(8'h00);

      // 100-cycle glitch straddling one tick must not press
      wait_ticks(1);
      idle(52);
      btn_n = 1'b0;
      idle(100);
      btn_n = 1'b1;
      wait_ticks(5);
      read_cmd(8'h00);

      // Press: one low sample is not enough, the second commits it
      btn_n = 1'b0;
      wait_ticks(1);
      read_cmd(8'h00);
      auto_exp(8'h03);
      wait_ticks(1);
      read_cmd(8'h03);
      read_cmd(8'h01);
      wait_ticks(2);
      read_cmd(8'h01);

      // Release
      btn_n = 1'b1;
      wait_ticks(1);
      read_cmd(8'h01);
      auto_exp(8'h04);
      wait_ticks(3);
      read_cmd(8'h04);

      // Noisy button, samples alternate low/high at every tick
      for (int k = 0; k < 6; k++) begin
         repeat (100) begin
            @(negedge clk);
            lfsr  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            btn_n = lfsr[0];
         end
         btn_n = (k % 2 == 0) ? 1'b0 : 1'b1;
         wait_ticks(1);
      end
      read_cmd(8'h00);
      btn_n = 1'b0;
      auto_exp(8'h03);
      wait_ticks(2);
      read_cmd(8'h03);

      // Clear command: both flags set, clear gives no response
      btn_n = 1'b1;
      auto_exp(8'h04);
      wait_ticks(2);
      btn_n = 1'b0;
      auto_exp(8'h07);
      wait_ticks(2);
      cmd(8'h02);
      idle(3);
      read_cmd(8'h01);
      idle(2);
      cmd(8'hFC);
      idle(3);

      // Back-to-back reads
      read_cmd(8'h01);
      read_cmd(8'h01);
      idle(4);

      // Reset while a response is on the bus
      stb_i = 1'b1;
      dat_i = 8'h01;
      @(posedge clk);
      #1;
      check("pending_stb", stb_o, 1);
      check("pending_dat", dat_o, 8'h01);
      #1;
      rst_n = 1'b0;
      stb_i = 1'b0;
      dat_i = 8'h00;
      #1;
      check("midrst_stb", stb_o, 0);
      check("midrst_dat", dat_o, 0);
      check("midrst_alive", alive, 0);
      idle(4);
      rst_n = 1'b1;
      read_cmd(8'h00);
      auto_exp(8'h03);
      wait_ticks(2);
      read_cmd(8'h03);
      wait_ticks(9);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      while (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL missing_response: got no STB_O, expected DAT_O=%02h", exp_q.pop_front());
      end
      checks++;
      if (alive_checks < 2) begin
         errors++;
         $display("FAIL alive_seen: got %0d heartbeat intervals, expected at least 2", alive_checks);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prewish_debounce.md
Name: prewish_debounce

Overview:
Debounces one active-low push-button input against a slow debounce tick (i_dbclock) supplied by a shared divider, all inside the single CLK_I domain. Exposes the debounced state and latched press/release events through the prewish strobe/byte interface. The student side (STB_I/DAT_I) takes commands; the mentor side (STB_O/DAT_O) returns a status byte. o_alive is a debug heartbeat for an LED.

Parameters:
NUM_SAMPLES, 2, consecutive agreeing debounce-tick samples required to change debounced state (min 2, max 8).
ALIVE_DIV_BITS, 3, o_alive toggles every 2^ALIVE_DIV_BITS debounce ticks.

Ports:
CLK_I  in  1  system clock; all logic is synchronous to its rising edge.
RST_I  in  1  asynchronous, active-low reset.
STB_O  out  1  one-cycle strobe; DAT_O is valid when high.
DAT_O  out  8  status byte.
STB_I  in  1  one-cycle command strobe.
DAT_I  in  8  command byte, sampled when STB_I=1.
iN_button  in  1  raw button pin, active low, asynchronous and bouncy.
i_dbclock  in  1  slow debounce tick, a level signal asynchronous to CLK_I; never used as a clock.
o_alive  out  1  heartbeat.

Behaviour:
- Reset (RST_I=0, immediate): STB_O=0, DAT_O=0, o_alive=0, debounced state=released, sample history all released, event flags=0, button synchronizer=1, dbclock synchronizer=0, alive counter=0.
- iN_button and i_dbclock each pass through a two-FF synchronizer.
- Tick: synchronized i_dbclock rising edge (previous 0, current 1). This is a one-cycle internal pulse.
- On each tick, shift the inverted synchronized button (1=pressed) into an NUM_SAMPLES-bit history.
- On the cycle after a tick: if the history is all 1s and the state is released, the state becomes pressed and press_flag is set. If the history is all 0s and the state is pressed, the state becomes released and release_flag is set. Any mixed history leaves the state unchanged.
- Consequence: a press shorter than one tick period never changes the state.
- Commands (STB_I=1):
  - DAT_I[0]=1 (read): on the next cycle STB_O=1 for exactly one cycle. DAT_O is loaded with {5'b0, release_flag, press_flag, state}. Both flags clear on the same edge.
  - DAT_I[1]=1 (clear): clears both flags. It produces no response unless bit0 is also set.
  - Other DAT_I bits are ignored.
- DAT_O holds its value between responses.
- Back-to-back read strobes each produce one response, so STB_O may stay high on consecutive cycles.
- A state change in the same cycle as a read or clear: the new flag is set after the clear and is not lost. The snapshot shows the pre-change value.
- o_alive: ALIVE_DIV_BITS-bit counter of ticks; o_alive toggles on each counter wrap.
- Reset mid-operation: everything returns to reset values immediately, and any pending response is dropped.

Optional Feature:
Macro PREWISH_DEBOUNCE_AUTO_REPORT_EN.
- Defined: every debounced state change also issues an unsolicited STB_O pulse with the status byte, one cycle after the state update. Flags are not cleared by this auto-report. If a read response falls in the same cycle, one combined response is sent and the flags are cleared.
- Undefined: STB_O is asserted only in response to read commands.

Decomposition:
- Package prewish_pkg holds:
  - status bit index constants: STAT_STATE=0, STAT_PRESS=1, STAT_RELEASE=2;
  - command bit constants: CMD_READ=0, CMD_CLEAR=1.
- One sub-module, prewish_sync2: a generic two-FF synchronizer with a reset value parameter, instanced twice.

Test Plan:
- Reset released after 15 cycles, button held 1, read command -> STB_O one cycle later, DAT_O=8'h00.
- i_dbclock period 128 CLK_I cycles (50% duty); button low for 100 cycles straddling at most one tick -> after 5 ticks, read gives DAT_O=8'h00.
- Button low for 4 tick periods -> state pressed after the 2nd low tick; read gives 8'h03; a second read gives 8'h01.
- Then button high for 4 periods -> read gives 8'h04; with a noisy LFSR button, no state change occurs until 2 agreeing ticks.
- Clear command (DAT_I=8'h02) after a press -> no STB_O; a subsequent read gives 8'h01. Reset asserted mid-press -> DAT_O=0, STB_O=0 immediately.
- o_alive toggles exactly every 8 ticks. With PREWISH_DEBOUNCE_AUTO_REPORT_EN defined, a press yields an unsolicited STB_O with DAT_O=8'h03.
